// File: rtl/reg_file_param_if.sv
// rtl/reg_file_param_if.sv - bus bundle for the parametrised 2R/1W register file
interface reg_file_param_if #(
    parameter int WIDTH = 64,
    parameter int AW    = 5
);
    logic             clr;
    logic             init_busy;
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic             rd_en;
    logic [AW-1:0]    ra0;
    logic [AW-1:0]    ra1;
    logic [WIDTH-1:0] rd0;
    logic [WIDTH-1:0] rd1;
    logic             rd_valid;

    modport master (
        output clr, we, wa, wd, rd_en, ra0, ra1,
        input  init_busy, rd0, rd1, rd_valid
    );

    modport slave (
        input  clr, we, wa, wd, rd_en, ra0, ra1,
        output init_busy, rd0, rd1, rd_valid
    );
endinterface

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised 2R/1W register file with bypass, registered reads and sequential clear
module reg_file_param #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_file_param_if.slave   bus
);
    localparam logic [31:0] DEPTH_U = DEPTH;
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e           state_q;
    logic [AW-1:0]    cnt_q;
    logic             busy_q;
    logic [WIDTH-1:0] rd0_q, rd1_q;
    logic [WIDTH-1:0] rd0_d, rd1_d;
    logic             rd_valid_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic wa_ok, ra0_ok, ra1_ok;
    logic init_wr, run_wr;

    always_comb begin
        wa_ok  = {{(32-AW){1'b0}}, bus.wa}  < DEPTH_U;
        ra0_ok = {{(32-AW){1'b0}}, bus.ra0} < DEPTH_U;
        ra1_ok = {{(32-AW){1'b0}}, bus.ra1} < DEPTH_U;
        init_wr = (state_q == ST_INIT) && !bus.clr;
        run_wr  = (state_q == ST_RUN) && !bus.clr && bus.we && wa_ok
                  && !((ZERO_REG != 0) && (bus.wa == '0));
    end

    // Read priority: out of range, hardwired zero, same-cycle bypass, stored entry.
    always_comb begin
        rd0_d = '0;
        if (ra0_ok && !((ZERO_REG != 0) && (bus.ra0 == '0))) begin
            if ((BYPASS != 0) && run_wr && (bus.wa == bus.ra0)) rd0_d = bus.wd;
            else                                                rd0_d = mem_q[bus.ra0];
        end
        rd1_d = '0;
        if (ra1_ok && !((ZERO_REG != 0) && (bus.ra1 == '0))) begin
            if ((BYPASS != 0) && run_wr && (bus.wa == bus.ra1)) rd1_d = bus.wd;
            else                                                rd1_d = mem_q[bus.ra1];
        end
    end

    // The array has no reset; the clear engine zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (init_wr)     mem_q[cnt_q]  <= '0;
        else if (run_wr) mem_q[bus.wa] <= bus.wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            rd0_q      <= '0;
            rd1_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    if (bus.clr) begin
                        cnt_q <= '0;
                    end else if (cnt_q == LAST) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                ST_RUN: begin
                    if (bus.clr) begin
                        state_q <= ST_INIT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else if (bus.rd_en) begin
                        rd0_q      <= rd0_d;
                        rd1_q      <= rd1_d;
                        rd_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.init_busy = busy_q;
    assign bus.rd0       = rd0_q;
    assign bus.rd1       = rd1_q;
    assign bus.rd_valid  = rd_valid_q;
endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - directed vector bench for reg_file_param in two configurations
module tb_reg_file_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_file_param_if #(.WIDTH(64), .AW(5)) a_if ();
    reg_file_param_if #(.WIDTH(16), .AW(5)) b_if ();

    reg_file_param #(.WIDTH(64), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if)
    );
    reg_file_param #(.WIDTH(16), .DEPTH(20), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        rd_en;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [63:0] e0;
        logic [63:0] e1;
        logic        ev;
    } vec_t;

    vec_t vt [12];
    int total = 0;
    int bad = 0;
    int na, nb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_if.clr = 1'b0; a_if.we = 1'b0; a_if.wa = '0; a_if.wd = '0;
        a_if.rd_en = 1'b0; a_if.ra0 = '0; a_if.ra1 = '0;
    endtask

    task automatic idle_b();
        b_if.clr = 1'b0; b_if.we = 1'b0; b_if.wa = '0; b_if.wd = '0;
        b_if.rd_en = 1'b0; b_if.ra0 = '0; b_if.ra1 = '0;
    endtask

    // Edges until both configurations leave the clear sequence, counted from now.
    task automatic count_ready(output int ca, output int cb);
        ca = 0; cb = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (ca == 0 && !a_if.init_busy) ca = i;
            if (cb == 0 && !b_if.init_busy) cb = i;
            if (ca != 0 && cb != 0) break;
        end
    endtask

    task automatic wait_a(output int n);
        n = 0;
        while (a_if.init_busy && n < 100) begin
            step();
            n++;
        end
    endtask

    initial begin
        idle_a();
        idle_b();
        vt[0]  = '{1'b0, 5'd0,  64'h0,                 1'b1, 5'd3,  5'd31, 64'h0,                 64'h0,                 1'b1};
        vt[1]  = '{1'b1, 5'd5,  64'hDEAD_BEEF_0123_4567, 1'b0, 5'd0,  5'd0,  64'h0,                 64'h0,                 1'b0};
        vt[2]  = '{1'b0, 5'd0,  64'h0,                 1'b1, 5'd5,  5'd5,  64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b1};
        vt[3]  = '{1'b1, 5'd7,  64'hA5,                1'b1, 5'd7,  5'd5,  64'hA5,                64'hDEAD_BEEF_0123_4567, 1'b1};
        vt[4]  = '{1'b1, 5'd0,  64'hFF,                1'b0, 5'd0,  5'd0,  64'hA5,                64'hDEAD_BEEF_0123_4567, 1'b0};
        vt[5]  = '{1'b0, 5'd0,  64'h0,                 1'b1, 5'd0,  5'd7,  64'h0,                 64'hA5,                1'b1};
        vt[6]  = '{1'b1, 5'd31, 64'h1,                 1'b1, 5'd31, 5'd31, 64'h1,                 64'h1,                 1'b1};
        vt[7]  = '{1'b0, 5'd0,  64'h0,                 1'b0, 5'd0,  5'd0,  64'h1,                 64'h1,                 1'b0};
        vt[8]  = '{1'b0, 5'd0,  64'h0,                 1'b1, 5'd9,  5'd31, 64'h0,                 64'h1,                 1'b1};
        vt[9]  = '{1'b1, 5'd9,  64'h77,                1'b1, 5'd10, 5'd9,  64'h0,                 64'h77,                1'b1};
        vt[10] = '{1'b0, 5'd0,  64'h0,                 1'b1, 5'd9,  5'd10, 64'h77,                64'h0,                 1'b1};
        vt[11] = '{1'b1, 5'd0,  64'hEE,                1'b1, 5'd0,  5'd9,  64'h0,                 64'h77,                1'b1};

        // Reset values
        step(); step();
        check("rst a busy", {63'd0, a_if.init_busy}, 64'd1);
        check("rst a rd0", a_if.rd0, 64'd0);
        check("rst a valid", {63'd0, a_if.rd_valid}, 64'd0);
        check("rst b busy", {63'd0, b_if.init_busy}, 64'd1);
        rst_n = 1'b1;
        count_ready(na, nb);
        check("init cycles a", 64'(na), 64'd32);
        check("init cycles b", 64'(nb), 64'd20);

        // All entries read back as zero after the clear sequence
        for (int i = 0; i < 32; i++) begin
            a_if.rd_en = 1'b1; a_if.ra0 = 5'(i); a_if.ra1 = 5'(31 - i);
            step();
            check($sformatf("clear rd0[%0d]", i), a_if.rd0, 64'd0);
            check($sformatf("clear rd1[%0d]", 31 - i), a_if.rd1, 64'd0);
        end
        check("clear valid", {63'd0, a_if.rd_valid}, 64'd1);
        idle_a();

        for (int i = 0; i < 12; i++) begin
            a_if.we = vt[i].we; a_if.wa = vt[i].wa; a_if.wd = vt[i].wd;
            a_if.rd_en = vt[i].rd_en; a_if.ra0 = vt[i].ra0; a_if.ra1 = vt[i].ra1;
            step();
            check($sformatf("vec%0d rd0", i), a_if.rd0, vt[i].e0);
            check($sformatf("vec%0d rd1", i), a_if.rd1, vt[i].e1);
            check($sformatf("vec%0d valid", i), {63'd0, a_if.rd_valid}, {63'd0, vt[i].ev});
        end
        idle_a();

        // clr while running re-clears the whole array
        a_if.clr = 1'b1;
        step();
        a_if.clr = 1'b0;
        check("clr run busy", {63'd0, a_if.init_busy}, 64'd1);
        wait_a(na);
        check("clr run cycles", 64'(na), 64'd32);
        a_if.we = 1'b1; a_if.wa = 5'd31; a_if.wd = 64'h33;
        a_if.rd_en = 1'b1; a_if.ra0 = 5'd5; a_if.ra1 = 5'd9;
        step();
        check("clr run rd0", a_if.rd0, 64'd0);
        check("clr run rd1", a_if.rd1, 64'd0);
        a_if.we = 1'b0; a_if.ra0 = 5'd31;
        step();
        check("pre init rd0", a_if.rd0, 64'h33);

        // clr on the 10th INIT edge restarts the count; INIT traffic is dropped
        a_if.clr = 1'b1; a_if.rd_en = 1'b0;
        step();
        a_if.clr = 1'b0;
        a_if.we = 1'b1; a_if.wa = 5'd4; a_if.wd = 64'h55;
        a_if.rd_en = 1'b1; a_if.ra0 = 5'd4; a_if.ra1 = 5'd4;
        for (int i = 1; i < 10; i++) step();
        check("init hold rd0", a_if.rd0, 64'h33);
        check("init valid", {63'd0, a_if.rd_valid}, 64'd0);
        check("init busy", {63'd0, a_if.init_busy}, 64'd1);
        a_if.clr = 1'b1;
        step();
        a_if.clr = 1'b0;
        wait_a(na);
        check("clr restart cycles", 64'(10 + na), 64'd42);
        idle_a();
        a_if.rd_en = 1'b1; a_if.ra0 = 5'd4; a_if.ra1 = 5'd31;
        step();
        check("init write lost", a_if.rd0, 64'd0);
        check("init recleared", a_if.rd1, 64'd0);
        idle_a();

        // Configuration without bypass or zero register, DEPTH=20
        b_if.we = 1'b1; b_if.wa = 5'd7; b_if.wd = 16'h0011;
        step();
        b_if.wd = 16'h00A5; b_if.rd_en = 1'b1; b_if.ra0 = 5'd7; b_if.ra1 = 5'd7;
        step();
        check("b nobypass rd0", 64'(b_if.rd0), 64'h11);
        check("b nobypass rd1", 64'(b_if.rd1), 64'h11);
        b_if.we = 1'b0;
        step();
        check("b after rd0", 64'(b_if.rd0), 64'hA5);
        b_if.we = 1'b1; b_if.wa = 5'd0; b_if.wd = 16'h00FF; b_if.rd_en = 1'b0;
        step();
        b_if.wa = 5'd19; b_if.wd = 16'h1919; b_if.rd_en = 1'b1; b_if.ra0 = 5'd0; b_if.ra1 = 5'd19;
        step();
        check("b reg0 rd0", 64'(b_if.rd0), 64'hFF);
        check("b old 19", 64'(b_if.rd1), 64'h0);
        b_if.wa = 5'd25; b_if.wd = 16'hBEEF; b_if.ra0 = 5'd25; b_if.ra1 = 5'd19;
        step();
        check("b oob rd0", 64'(b_if.rd0), 64'h0);
        check("b last rd1", 64'(b_if.rd1), 64'h1919);
        b_if.we = 1'b0; b_if.ra0 = 5'd25; b_if.ra1 = 5'd7;
        step();
        check("b oob again", 64'(b_if.rd0), 64'h0);
        check("b unchanged 7", 64'(b_if.rd1), 64'hA5);

        // Reset pulse in the middle of a read
        a_if.we = 1'b1; a_if.wa = 5'd3; a_if.wd = 64'hABC;
        step();
        a_if.we = 1'b0; a_if.rd_en = 1'b1; a_if.ra0 = 5'd3; a_if.ra1 = 5'd3;
        b_if.ra0 = 5'd0;
        step();
        check("pre rst a rd0", a_if.rd0, 64'hABC);
        check("pre rst b rd0", 64'(b_if.rd0), 64'hFF);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst a rd0", a_if.rd0, 64'd0);
        check("mid rst a rd1", a_if.rd1, 64'd0);
        check("mid rst a valid", {63'd0, a_if.rd_valid}, 64'd0);
        check("mid rst a busy", {63'd0, a_if.init_busy}, 64'd1);
        check("mid rst b rd0", 64'(b_if.rd0), 64'd0);
        check("mid rst b valid", {63'd0, b_if.rd_valid}, 64'd0);
        idle_a();
        idle_b();
        step();
        rst_n = 1'b1;
        count_ready(na, nb);
        check("rerun cycles a", 64'(na), 64'd32);
        check("rerun cycles b", 64'(nb), 64'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
